tt_um_serial_adder: RTL and testbench
=====================================

TT_UM_SERIAL_ADDER -- requirements
Module: tt_um_serial_adder

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  design enable; low freezes all state.
REQ-005 ui_in  input  8  [0]=a bit, [1]=b bit, [2]=bit_valid, [3]=start, [4]=sub (SERIAL_ADD_SUB_EN only), [7:5] unused.
REQ-006 uio_in  input  8  unused, ignored.
REQ-007 uo_out  output  8  result register, sum/difference bits.
REQ-008 uio_out  output  8  [0]=done, [1]=carry_out, [2]=busy, [3]=ovf (signed overflow), [7:4]=0.
REQ-009 uio_oe  output  8  constant 8'h0F.

Function
REQ-010 The block SHALL be a bit-serial adder: operands enter LSB first, one bit pair per accepted cycle, via a registered full-add stage with carry flop.
REQ-011 FSM states SHALL be IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-012 start=1 in any state SHALL go to RUN next cycle, clear bit counter (3 bits) and result, set carry to cin (0 for add).
REQ-013 In RUN, bit_valid=1 SHALL compute s=a^b^c, update c to majority(a,b,c), shift result right with s entering bit 7, increment counter.
REQ-014 bit_valid=0 in RUN SHALL hold all state; gaps of any length between bits are legal.
REQ-015 The accepted bit with counter=7 SHALL transition to DONE, latch carry_out=final carry, latch ovf=(carry into bit 7) XOR (carry out of bit 7); counter wraps to 0.
REQ-016 After 8 accepted bits uo_out SHALL equal (A op B) mod 256 with A,B bit-aligned LSB-first; latency from 8th bit to done=1 is one cycle.
REQ-017 DONE SHALL hold result, carry_out, ovf until next start; bit_valid in IDLE or DONE SHALL be ignored.
REQ-018 start and bit_valid in the same cycle SHALL give start priority; that bit is discarded.
REQ-019 start during RUN SHALL abort the operation and restart per REQ-012; no done pulse for the aborted operation.
REQ-020 carry_out and ovf SHALL read 0 outside DONE; uo_out SHALL show the partial shift register during RUN.
REQ-021 ena=0 SHALL block all state changes including start; outputs hold their current values.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, counter=0, carry=0, result=8'h00, carry_out=0, ovf=0, regardless of ena.
REQ-023 Reset during RUN SHALL discard the partial operation; no done pulse follows.
REQ-024 After reset all outputs SHALL read: uo_out=8'h00, uio_out=8'h00, uio_oe=8'h0F.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN SHALL compile in subtract mode: ui_in[4] sampled at start selects sub; in sub, b is inverted per bit and cin=1, carry_out=1 meaning no borrow.
REQ-026 Without SERIAL_ADD_SUB_EN, ui_in[4] SHALL be ignored and the block SHALL only add.

Verification
REQ-027 Reset, start, stream 0x5A+0x3C back-to-back -> uo_out=0x96, carry_out=0, ovf=1, done=1 one cycle after 8th bit.
REQ-028 0xFF+0x01 with 3-cycle gaps between bits -> uo_out=0x00, carry_out=1, ovf=0.
REQ-029 0x7F+0x01 -> uo_out=0x80, carry_out=0, ovf=1; bit_valid pulses in DONE leave result unchanged.
REQ-030 Start, 4 bits, start again (same cycle as bit_valid), then 0x12+0x34 -> uo_out=0x46, exactly one done; rst_n=0 mid-RUN -> all outputs 0, uio_oe=0x0F.
REQ-031 With SERIAL_ADD_SUB_EN, sub=1: 0x10-0x01 -> uo_out=0x0F, carry_out=1; 0x01-0x02 -> uo_out=0xFF, carry_out=0.
REQ-032 ena=0 while streaming 0x0F+0x01 -> no state change; resume ena=1 -> uo_out=0x10.

Source files
------------

// File: rtl/tt_um_serial_adder_if.sv
// ---------------------------------------------------------------------------
// tt_um_serial_adder_if
// Groups the TinyTapeout-style I/O bus of the bit-serial adder.
//   ui_in   [7:0]  operand bits, bit_valid, start, sub select
//   uio_in  [7:0]  unused by the adder
//   uo_out  [7:0]  result shift register
//   uio_out [7:0]  {4'b0, ovf, busy, carry_out, done}
//   uio_oe  [7:0]  output enables for uio_out
// Modports: master drives the inputs and observes the outputs;
//           slave is the adder side.
// ---------------------------------------------------------------------------
interface tt_um_serial_adder_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_serial_adder.sv
// ---------------------------------------------------------------------------
// tt_um_serial_adder
// 8-bit bit-serial adder. Operands arrive LSB first, one bit pair per cycle
// with bit_valid high; a single full-add stage with a carry flop produces one
// sum bit per accepted pair, shifted into the result from the top.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (wins over ena)
//   ena    design enable; low freezes all state
//   bus    tt_um_serial_adder_if.slave
//            ui_in[0]=a, [1]=b, [2]=bit_valid, [3]=start, [4]=sub
//            uo_out = result, uio_out = {4'b0, ovf, busy, carry_out, done}
//            uio_oe = 8'h0F
//
// Optional feature: define SERIAL_ADD_SUB_EN to enable subtraction. ui_in[4]
// sampled with start selects subtract (b inverted per bit, carry-in 1,
// carry_out=1 meaning no borrow). Without it ui_in[4] is ignored.
// ---------------------------------------------------------------------------
module tt_um_serial_adder (
  input logic               clk,
  input logic               rst_n,
  input logic               ena,
  tt_um_serial_adder_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic [7:0] result_q, result_d;
  logic       cout_q, cout_d;
  logic       ovf_q, ovf_d;

  logic aBit, bBit, bitValid, startReq, cin;
  logic sumBit, carryNext;
  logic busy, done;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;

  // Subtract inverts b per bit and seeds the carry with 1 (two's complement).
  assign bBit = bus.ui_in[1] ^ sub_q;
  assign cin  = bus.ui_in[4];

  logic unused;
  assign unused = &{1'b0, bus.uio_in, bus.ui_in[7:5]};
`else
  assign bBit = bus.ui_in[1];
  assign cin  = 1'b0;

  logic unused;
  assign unused = &{1'b0, bus.uio_in, bus.ui_in[7:4]};
`endif

  assign aBit     = bus.ui_in[0];
  assign bitValid = bus.ui_in[2];
  assign startReq = bus.ui_in[3];

  assign sumBit    = aBit ^ bBit ^ carry_q;
  assign carryNext = (aBit & bBit) | (aBit & carry_q) | (bBit & carry_q);

  // Next-state logic. start has priority over a same-cycle bit and restarts
  // from any state; ena low leaves every register at its current value.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d    = sub_q;
`endif
    if (ena) begin
      if (startReq) begin
        state_d  = RUN;
        cnt_d    = 3'd0;
        carry_d  = cin;
        result_d = 8'h00;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_d    = bus.ui_in[4];
`endif
      end else if (state_q == RUN && bitValid) begin
        result_d = {sumBit, result_q[7:1]};
        carry_d  = carryNext;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // carry_q is the carry into bit 7 here; their XOR is signed overflow.
          state_d = DONE;
          cout_d  = carryNext;
          ovf_d   = carry_q ^ carryNext;
        end
      end
    end
  end

  // State registers with synchronous reset that takes effect even when ena=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      carry_q  <= 1'b0;
      result_q <= 8'h00;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // carry_out and ovf are only meaningful once the operation has completed.
  assign bus.uo_out  = result_q;
  assign bus.uio_out = {4'b0000, ovf_q & done, busy, cout_q & done, done};
  assign bus.uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_tt_um_serial_adder
// Self-checking bench for tt_um_serial_adder. Expected results come from a
// plain arithmetic model of A op B; directed scenarios plus random operands.
// Honours SERIAL_ADD_SUB_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_tt_um_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  tt_um_serial_adder_if bus ();

  tt_um_serial_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  int   assertCount = 0;
  int   failCount   = 0;
  int   doneEdges   = 0;
  logic donePrev    = 1'b0;

  // Counts entries into the done state, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.uio_out[0] === 1'b1 && donePrev !== 1'b1) doneEdges++;
    donePrev = bus.uio_out[0];
  end

  // Reference model: {ovf, carry_out, result} of A op B.
  function automatic logic [9:0] refOp(input logic [7:0] a, input logic [7:0] b,
                                       input logic sub);
    logic       s;
    logic [7:0] bEff;
    logic [8:0] full;
    logic       ovf;
    s    = sub & SUB_EN;
    bEff = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bEff} + {8'd0, s};
    ovf  = (a[7] == bEff[7]) && (full[7] != a[7]);
    return {ovf, full[8], full[7:0]};
  endfunction

  function automatic logic [7:0] mk(input logic a, input logic b, input logic valid,
                                    input logic start, input logic sub);
    return {3'b000, sub, start, valid, b, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ui);
    bus.ui_in = ui;
    @(posedge clk);
    #1;
    bus.ui_in = 8'h00;
  endtask

  task automatic startOp(input logic sub);
    applyStimulus(mk(1'b0, 1'b0, 1'b0, 1'b1, sub));
    checkOutput("start_uo", bus.uo_out, 8'h00);
    checkOutput("start_uio", bus.uio_out, 8'h04);
  endtask

  // Streams bits [lo..hi] of A and B, with idle gaps carrying junk a/b.
  task automatic streamBits(input logic [7:0] a, input logic [7:0] b,
                            input int lo, input int hi, input int maxGap,
                            input bit randGap);
    int gap;
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(mk(a[i], b[i], 1'b1, 1'b0, 1'b0));
      if (i < 7) begin
        gap = randGap ? $urandom_range(maxGap, 0) : maxGap;
        for (int g = 0; g < gap; g++)
          applyStimulus(mk(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic checkDone(input string tag, input logic [7:0] a,
                           input logic [7:0] b, input logic sub);
    logic [9:0] r;
    r = refOp(a, b, sub);
    checkOutput({tag, "_uo"}, bus.uo_out, r[7:0]);
    checkOutput({tag, "_uio"}, bus.uio_out, {4'b0000, r[9], 1'b0, r[8], 1'b1});
  endtask

  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input int maxGap, input bit randGap);
    logic [9:0] r;
    r = refOp(a, b, sub);
    startOp(sub);
    streamBits(a, b, 0, 3, maxGap, randGap);
    checkOutput({tag, "_partial"}, bus.uo_out, {r[3:0], 4'b0000});
    checkOutput({tag, "_busy"}, bus.uio_out, 8'h04);
    streamBits(a, b, 4, 7, maxGap, randGap);
    checkDone(tag, a, b, sub);
  endtask

  initial begin
    logic [7:0] a, b, held;
    logic [9:0] r;
    logic       s;

    bus.ui_in  = 8'h00;
    bus.uio_in = 8'hA5;
    ena        = 1'b0;
    rst_n      = 1'b0;

    // Reset takes effect even with ena low.
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("reset_uo", bus.uo_out, 8'h00);
    checkOutput("reset_uio", bus.uio_out, 8'h00);
    checkOutput("reset_oe", bus.uio_oe, 8'h0F);
    rst_n = 1'b1;
    ena   = 1'b1;
    applyStimulus(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    checkOutput("idle_bit_ignored", bus.uio_out, 8'h00);

    // Back-to-back bits, done visible right after the 8th bit.
    runOp("add5A3C", 8'h5A, 8'h3C, 1'b0, 0, 1'b0);

    // Three idle cycles between bits.
    runOp("addFF01", 8'hFF, 8'h01, 1'b0, 3, 1'b0);

    // Signed overflow, then bit_valid pulses in DONE must change nothing.
    runOp("add7F01", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0));
    checkDone("done_hold", 8'h7F, 8'h01, 1'b0);

    // Abort after 4 bits with start+bit_valid together, then 0x12+0x34.
    doneEdges = 0;
    startOp(1'b0);
    streamBits(8'hAA, 8'h55, 0, 3, 0, 1'b0);
    applyStimulus(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    checkOutput("abort_uo", bus.uo_out, 8'h00);
    checkOutput("abort_uio", bus.uio_out, 8'h04);
    streamBits(8'h12, 8'h34, 0, 7, 0, 1'b0);
    checkDone("add1234", 8'h12, 8'h34, 1'b0);
    applyStimulus(8'h00);
    checkOutput("done_count", 8'(doneEdges), 8'd1);

    // Reset in the middle of an operation.
    startOp(1'b0);
    streamBits(8'hFF, 8'h00, 0, 4, 0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(8'h00);
    checkOutput("midrst_uo", bus.uo_out, 8'h00);
    checkOutput("midrst_uio", bus.uio_out, 8'h00);
    checkOutput("midrst_oe", bus.uio_oe, 8'h0F);
    rst_n = 1'b1;
    streamBits(8'hFF, 8'h00, 5, 7, 0, 1'b0);
    checkOutput("midrst_nodone", bus.uio_out, 8'h00);

    // ena low freezes everything, including start.
    startOp(1'b0);
    streamBits(8'h0F, 8'h01, 0, 2, 0, 1'b0);
    r    = refOp(8'h0F, 8'h01, 1'b0);
    held = {r[2:0], 5'b00000};
    ena  = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    checkOutput("ena_hold_uo", bus.uo_out, held);
    checkOutput("ena_hold_uio", bus.uio_out, 8'h04);
    ena = 1'b1;
    streamBits(8'h0F, 8'h01, 3, 7, 0, 1'b0);
    checkDone("ena_resume", 8'h0F, 8'h01, 1'b0);
    checkOutput("ena_result", bus.uo_out, 8'h10);

    // Subtract select: real subtraction with the feature, plain add without.
    runOp("sub1001", 8'h10, 8'h01, 1'b1, 0, 1'b0);
    runOp("sub0102", 8'h01, 8'h02, 1'b1, 1, 1'b0);

    // Random operands, random gaps, random DONE noise.
    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      runOp("rand", a, b, s, 2, 1'b1);
      for (int i = 0; i < 2; i++)
        applyStimulus(mk(1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0));
      checkDone("rand_hold", a, b, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
